mult_seq_ctrl: RTL and testbench

Sequential shift-and-add multiplier controller that time-shares one external N-bit ripple adder (somador chain) to form an unsigned N x N -> 2N product. It owns the accumulator, multiplier shift register and iteration counter. It drives the adder operand inputs and takes back the (N+1)-bit sum. It sits between the board switch/key inputs and the display decoders in the lab top level.

---
 rtl/mult_seq_ctrl.sv | 99 +++++++++
 tb/tb_mult_seq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_ctrl
// Brief    : Shift-and-add N x N -> 2N unsigned multiplier controller that
//            time-shares one external ripple adder.
// Revision : 1.0
// ============================================================================
module mult_seq_ctrl #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic [N-1:0]     add_a,
    output logic [N-1:0]     add_b,
    output logic             add_cin,
    input  logic [N:0]       add_s,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int c_cw = $clog2(N + 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_add   = 2'd1;
    localparam logic [1:0] c_shift = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam logic [c_cw-1:0] c_last = c_cw'(N - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    logic [1:0]       r_state;
    logic [N-1:0]     r_mcand;
    logic [N-1:0]     r_acc;
    logic             r_carry;
    logic [N-1:0]     r_mq;
    logic [c_cw-1:0]  r_count;
    logic [2*N-1:0]   r_product;

    // Logical right shift of {carry, acc, mq} by one; a zero enters at the top.
    logic [2*N:0]     w_shifted;

    assign w_shifted = {1'b0, r_carry, r_acc, r_mq[N-1:1]};

    assign add_a   = r_acc;
    assign add_b   = r_mq[0] ? r_mcand : '0;
    assign add_cin = 1'b0;
    assign busy    = (r_state == c_add) || (r_state == c_shift);
    assign done    = (r_state == c_done);
    assign product = r_product;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_idle;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_carry   <= 1'b0;
            r_mq      <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_mcand <= A;
                        r_mq    <= B;
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                        r_count <= '0;
                        r_state <= c_add;
                    end
                end
                c_add: begin
                    // Adder carry-out is kept so the next shift brings it into acc.
                    {r_carry, r_acc} <= add_s;
                    r_state          <= c_shift;
                end
                c_shift: begin
                    {r_carry, r_acc, r_mq} <= w_shifted;
                    r_count                <= r_count + c_one;
                    if (r_count == c_last) begin
                        r_product <= w_shifted[2*N-1:0];
                        r_state   <= c_done;
                    end else begin
                        r_state   <= c_add;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_ctrl
// Brief    : Self-checking bench for mult_seq_ctrl with an arithmetic model
//            and a behavioural model of the external adder.
// Revision : 1.0
// ============================================================================
module tb_mult_seq_ctrl;

    localparam int N = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic [N-1:0]     add_a;
    logic [N-1:0]     add_b;
    logic             add_cin;
    logic [N:0]       add_s;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    int vectors     = 0;
    int miscompares = 0;
    logic chk_en     = 1'b0;
    logic carry_seen = 1'b0;

    // Model: m_t = cycles since accepted start (0 when idle).
    int             m_t    = 0;
    logic [N-1:0]   m_a    = '0;
    logic [N-1:0]   m_b    = '0;
    logic [2*N-1:0] m_prod = '0;

    mult_seq_ctrl #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .A       (A),
        .B       (B),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_cin (add_cin),
        .add_s   (add_s),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    assign add_s = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_t    <= 0;
            m_prod <= '0;
        end else if (m_t == 0) begin
            if (start) begin
                m_t <= 1;
                m_a <= A;
                m_b <= B;
            end
        end else if (m_t == 2*N + 1) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
            if (m_t == 2*N) m_prod <= m_a * m_b;
        end
    end

    initial begin
        int run;
        int k;
        int pk;
        int bb;
        int exp_a;
        run = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy", busy, (m_t >= 1 && m_t <= 2*N));
                check("done", done, (m_t == 2*N + 1));
                check("product", product, m_prod);
                check("add_cin", add_cin, 0);
                if (m_t >= 1 && m_t <= 2*N) begin
                    // Partial product after k iterations, seen through the acc window.
                    k  = (m_t - 1) / 2;
                    pk = (int'(m_a) * (int'(m_b) % (1 << k))) >> k;
                    bb = m_b[k] ? int'(m_a) : 0;
                    exp_a = (m_t % 2 == 1) ? pk : ((pk + bb) % (1 << N));
                    check("add_a", add_a, exp_a);
                    check("add_b", add_b, bb);
                    if (add_s[N]) carry_seen = 1'b1;
                end
                if (done) check("busy_run", run, 2*N);
                if (busy) run++;
                else run = 0;
            end
        end
    end

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int exp_lit, input string nm);
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = 4'($urandom); B = 4'($urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 40);
        check({"latency_", nm}, cyc, 2*N + 1);
        check({"prod_", nm}, product, exp_lit);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        @(posedge clk); #1 reset = 1'b0;

        run_op(4'd7, 4'd3, 21, "7x3");
        carry_seen = 1'b0;
        run_op(4'd15, 4'd15, 225, "15x15");
        check("carry_seen", carry_seen, 1);
        run_op(4'd0, 4'd9, 0, "0x9");
        run_op(4'd13, 4'd0, 0, "13x0");

        // Start while busy must be ignored.
        @(posedge clk); #1 start = 1'b1; A = 4'd5; B = 4'd6;
        @(posedge clk); #1 A = 4'd1; B = 4'd1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin @(negedge clk); cyc++; end
        check("prod_ignore", product, 30);
        run_op(4'd2, 4'd4, 8, "2x4");

        // Reset during the third busy cycle abandons the operation.
        @(posedge clk); #1 start = 1'b1; A = 4'd9; B = 4'd9;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_product", product, 0);
        repeat (12) @(negedge clk);
        run_op(4'd3, 4'd4, 12, "3x4");

        // Exhaustive sweep with start held high.
        @(posedge clk); #1 start = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                A = 4'(a); B = 4'(b);
                cyc = 0;
                while (!(m_t == 1 && m_a == 4'(a) && m_b == 4'(b)) && cyc < 30) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                if (cyc >= 30) check("sweep_accept", 0, 1);
            end
        end
        start = 1'b0;
        repeat (12) @(posedge clk);

        // Random start/operand/reset traffic.
        repeat (800) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) != 0);
            A     = 4'($urandom);
            B     = 4'($urandom);
            reset = ($urandom_range(0, 99) == 0);
        end
        #1 reset = 1'b0; start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
